// File: rtl/lfsr_sched_if.sv
// lfsr_sched_if: request/grant/data handshake between lfsr_sched and its two
// word consumers.
//   req       [1:0]      per-requester word request (level, held until ack)
//   ack       [1:0]      per-requester accept, meaningful only with own gnt bit
//   gnt       [1:0]      one-hot grant, 00 when nothing is being delivered
//   rnd_data  [WIDTH-1:0] captured LFSR word
//   rnd_valid            rnd_data valid for the granted requester
// master = consumer side, slave = scheduler side.
interface lfsr_sched_if #(
  parameter int WIDTH = 17
);
  logic [1:0]       req;
  logic [1:0]       ack;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] rnd_data;
  logic             rnd_valid;

  modport master (
    output req,
    output ack,
    input  gnt,
    input  rnd_data,
    input  rnd_valid
  );

  modport slave (
    input  req,
    input  ack,
    output gnt,
    output rnd_data,
    output rnd_valid
  );
endinterface

// File: rtl/lfsr_sched.sv
// lfsr_sched: shares one Fibonacci LFSR between two requesters. On start the
// LFSR is seeded; each delivered word is preceded by STEPS shifts to
// decorrelate consecutive words, then handed to one requester chosen
// round-robin, with a valid/ack handshake.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           (re)seed request, honoured in IDLE and ARB only
//   lfsr_q          LFSR state from the datapath
//   lfsr_max_tick   LFSR full-period pulse
//   lfsr_sh_en      LFSR shift enable
//   lfsr_rst_en     LFSR seed load
//   busy            high in every state except IDLE and ARB
//   period_cnt      max_tick pulses since last seed, wraps
//   lock_err        sticky all-zero LFSR flag
//   bus             lfsr_sched_if.slave: req/ack/gnt/rnd_data/rnd_valid
//
// Optional feature: define LFSR_SCHED_LOCKUP_DETECT_EN to check the captured
// word for the all-zero lockup state. A zero word is then not delivered; the
// LFSR is reseeded and the same requester is served again. Without the macro
// lock_err is tied low and a zero word is delivered like any other.
//
// state   | meaning
// IDLE    | waiting for start, requests ignored
// INIT    | one-cycle LFSR seed load, period_cnt cleared
// ARB     | pick next requester (start has priority)
// SHIFT   | LFSR shifting, STEPS cycles
// CAPT    | latch lfsr_q into rnd_data
// DELIV   | word offered to granted requester until ack or request drop
module lfsr_sched #(
  parameter int WIDTH = 17,
  parameter int STEPS = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] lfsr_q,
  input  logic             lfsr_max_tick,
  output logic             lfsr_sh_en,
  output logic             lfsr_rst_en,
  output logic             busy,
  output logic [CNT_W-1:0] period_cnt,
  output logic             lock_err,
  lfsr_sched_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ARB, S_SHIFT, S_CAPT, S_DELIV
  } state_t;

  // Step counter counts down to a terminal count of zero.
  localparam logic [7:0] STEPS_M1 = 8'(STEPS - 1);

  state_t     state;
  logic       g;        // latched winner for the word in flight
  logic       last_g;   // requester served last
  logic [7:0] step_cnt;
  logic       win;

`ifdef LFSR_SCHED_LOCKUP_DETECT_EN
  logic relock;         // INIT entered from a lockup: resume SHIFT for g
`else
  assign lock_err = 1'b0;
`endif

  // Both requesting: whoever was not served last. Single: that one.
  always_comb begin
    win = bus.req[1];
    if (bus.req == 2'b11) win = ~last_g;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      g             <= 1'b0;
      last_g        <= 1'b1;
      step_cnt      <= '0;
      lfsr_sh_en    <= 1'b0;
      lfsr_rst_en   <= 1'b0;
      busy          <= 1'b0;
      period_cnt    <= '0;
      bus.gnt       <= 2'b00;
      bus.rnd_data  <= '0;
      bus.rnd_valid <= 1'b0;
`ifdef LFSR_SCHED_LOCKUP_DETECT_EN
      lock_err      <= 1'b0;
      relock        <= 1'b0;
`endif
    end else begin
      // INIT clear wins over a coincident tick.
      if (state == S_INIT)
        period_cnt <= '0;
      else if (state != S_IDLE && lfsr_max_tick)
        period_cnt <= period_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_INIT;
            lfsr_rst_en <= 1'b1;
            busy        <= 1'b1;
          end
        end

        S_INIT: begin
          lfsr_rst_en <= 1'b0;
`ifdef LFSR_SCHED_LOCKUP_DETECT_EN
          if (relock) begin
            relock     <= 1'b0;
            state      <= S_SHIFT;
            lfsr_sh_en <= 1'b1;
            step_cnt   <= STEPS_M1;
          end else begin
`else
          begin
`endif
            state <= S_ARB;
            busy  <= 1'b0;
          end
        end

        S_ARB: begin
          if (start) begin
            state       <= S_INIT;
            lfsr_rst_en <= 1'b1;
            busy        <= 1'b1;
          end else if (|bus.req) begin
            g          <= win;
            state      <= S_SHIFT;
            lfsr_sh_en <= 1'b1;
            busy       <= 1'b1;
            step_cnt   <= STEPS_M1;
          end
        end

        S_SHIFT: begin
          if (step_cnt == 8'd0) begin
            lfsr_sh_en <= 1'b0;
            state      <= S_CAPT;
          end else begin
            step_cnt <= step_cnt - 8'd1;
          end
        end

        S_CAPT: begin
`ifdef LFSR_SCHED_LOCKUP_DETECT_EN
          if (lfsr_q == '0) begin
            lock_err    <= 1'b1;
            relock      <= 1'b1;
            state       <= S_INIT;
            lfsr_rst_en <= 1'b1;
          end else begin
`else
          begin
`endif
            bus.rnd_data  <= lfsr_q;
            bus.rnd_valid <= 1'b1;
            bus.gnt       <= g ? 2'b10 : 2'b01;
            state         <= S_DELIV;
          end
        end

        S_DELIV: begin
          if (bus.ack[g]) begin
            last_g        <= g;
            state         <= S_ARB;
            bus.rnd_valid <= 1'b0;
            bus.gnt       <= 2'b00;
            busy          <= 1'b0;
          end else if (!bus.req[g]) begin
            // Requester withdrew: word discarded, pointer untouched.
            state         <= S_ARB;
            bus.rnd_valid <= 1'b0;
            bus.gnt       <= 2'b00;
            busy          <= 1'b0;
          end
        end

        default: begin
          state         <= S_IDLE;
          lfsr_sh_en    <= 1'b0;
          lfsr_rst_en   <= 1'b0;
          busy          <= 1'b0;
          bus.rnd_valid <= 1'b0;
          bus.gnt       <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_sched.sv
module tb_lfsr_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [16:0] lfsr_q;
  logic        lfsr_max_tick = 1'b0;
  logic        lfsr_sh_en;
  logic        lfsr_rst_en;
  logic        busy;
  logic [7:0]  period_cnt;
  logic        lock_err;

  int checks = 0;
  int errors = 0;

  // Stimulus LFSR: 17-bit Fibonacci, taps 16 and 13, seed 0x00028.
  logic [16:0] lfsr_state = '0;
  logic        force_zero = 1'b0;

  // Expected words after 4, 8, 12, 16 shifts from the seed (hand-derived).
  logic [1:0]  exp_gnt  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [16:0] exp_word [4] = '{17'h00280, 17'h02800, 17'h0800B, 17'h000B4};

  lfsr_sched_if #(.WIDTH(17)) bus ();

  lfsr_sched #(.WIDTH(17), .STEPS(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .lfsr_q       (lfsr_q),
    .lfsr_max_tick(lfsr_max_tick),
    .lfsr_sh_en   (lfsr_sh_en),
    .lfsr_rst_en  (lfsr_rst_en),
    .busy         (busy),
    .period_cnt   (period_cnt),
    .lock_err     (lock_err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lfsr_rst_en)
      lfsr_state <= 17'h00028;
    else if (lfsr_sh_en)
      lfsr_state <= {lfsr_state[15:0], lfsr_state[16] ^ lfsr_state[13]};
  end

  assign lfsr_q = force_zero ? 17'h0 : lfsr_state;

  initial begin
    bus.req = 2'b00;
    bus.ack = 2'b00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; bus.req = 2'b00; bus.ack = 2'b00;
    lfsr_max_tick = 1'b0; force_zero = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  task automatic test_reset();
    tick();
    checks++; if (lfsr_sh_en !== 1'b0) begin errors++; $display("FAIL rst_sh_en: got %b expected 0", lfsr_sh_en); end
    checks++; if (lfsr_rst_en !== 1'b0) begin errors++; $display("FAIL rst_rst_en: got %b expected 0", lfsr_rst_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b expected 00", bus.gnt); end
    checks++; if (bus.rnd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.rnd_valid); end
    checks++; if (bus.rnd_data !== 17'h0) begin errors++; $display("FAIL rst_data: got %h expected 00000", bus.rnd_data); end
    checks++; if (period_cnt !== 8'h00) begin errors++; $display("FAIL rst_period: got %h expected 00", period_cnt); end
    checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL rst_lock_err: got %b expected 0", lock_err); end
    rst_n = 1'b1;
    bus.req = 2'b01;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0 || lfsr_sh_en !== 1'b0) begin errors++; $display("FAIL idle_ignores_req: got busy=%b sh_en=%b expected 0 0", busy, lfsr_sh_en); end
    bus.req = 2'b00;
  endtask

  task automatic test_single();
    int sh_cnt;
    do_reset();
    start = 1'b1; tick();
    checks++; if (lfsr_rst_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL init_rst_en: got rst_en=%b busy=%b expected 1 1", lfsr_rst_en, busy); end
    start = 1'b0; bus.req = 2'b01; tick();
    checks++; if (lfsr_rst_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arb_entry: got rst_en=%b busy=%b expected 0 0", lfsr_rst_en, busy); end
    sh_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (lfsr_sh_en) sh_cnt++;
      if (i == 5) begin
        checks++; if (bus.rnd_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", bus.rnd_valid); end
      end
    end
    checks++; if (sh_cnt != 4) begin errors++; $display("FAIL single_sh_cycles: got %0d expected 4", sh_cnt); end
    checks++; if (bus.rnd_valid !== 1'b1 || bus.gnt !== 2'b01) begin errors++; $display("FAIL single_valid_gnt: got valid=%b gnt=%b expected 1 01", bus.rnd_valid, bus.gnt); end
    checks++; if (bus.rnd_data !== 17'h00280) begin errors++; $display("FAIL single_data: got %h expected 00280", bus.rnd_data); end
    bus.ack = 2'b01; bus.req = 2'b00; tick(); bus.ack = 2'b00;
    checks++; if (bus.rnd_valid !== 1'b0 || bus.gnt !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got valid=%b gnt=%b busy=%b expected 0 00 0", bus.rnd_valid, bus.gnt, busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_start();
    bus.req = 2'b11;
    for (int w = 0; w < 4; w++) begin
      for (int i = 1; i <= 6; i++) tick();
      checks++; if (bus.rnd_valid !== 1'b1 || bus.gnt !== exp_gnt[w]) begin errors++; $display("FAIL b2b_gnt word %0d: got valid=%b gnt=%b expected 1 %b", w, bus.rnd_valid, bus.gnt, exp_gnt[w]); end
      checks++; if (bus.rnd_data !== exp_word[w]) begin errors++; $display("FAIL b2b_data word %0d: got %h expected %h", w, bus.rnd_data, exp_word[w]); end
      bus.ack = exp_gnt[w];
      if (w == 3) bus.req = 2'b00;
      tick();
      bus.ack = 2'b00;
      checks++; if (bus.rnd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_arb word %0d: got valid=%b busy=%b expected 0 0", w, bus.rnd_valid, busy); end
    end
  endtask

  task automatic test_delayed_ack();
    do_reset();
    do_start();
    bus.req = 2'b10;
    for (int i = 1; i <= 6; i++) tick();
    checks++; if (bus.rnd_valid !== 1'b1 || bus.gnt !== 2'b10 || bus.rnd_data !== 17'h00280) begin errors++; $display("FAIL dly_first: got valid=%b gnt=%b data=%h expected 1 10 00280", bus.rnd_valid, bus.gnt, bus.rnd_data); end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (bus.rnd_valid !== 1'b1 || bus.gnt !== 2'b10 || bus.rnd_data !== 17'h00280) begin errors++; $display("FAIL dly_hold %0d: got valid=%b gnt=%b data=%h expected 1 10 00280", i, bus.rnd_valid, bus.gnt, bus.rnd_data); end
      checks++; if (lfsr_sh_en !== 1'b0 || lfsr_rst_en !== 1'b0) begin errors++; $display("FAIL dly_lfsr_idle %0d: got sh_en=%b rst_en=%b expected 0 0", i, lfsr_sh_en, lfsr_rst_en); end
    end
    bus.ack = 2'b10; bus.req = 2'b00; tick(); bus.ack = 2'b00;
    checks++; if (bus.rnd_valid !== 1'b0 || bus.gnt !== 2'b00) begin errors++; $display("FAIL dly_release: got valid=%b gnt=%b expected 0 00", bus.rnd_valid, bus.gnt); end
    tick();
    checks++; if (busy !== 1'b0 || lfsr_rst_en !== 1'b0) begin errors++; $display("FAIL dly_start_not_queued: got busy=%b rst_en=%b expected 0 0", busy, lfsr_rst_en); end
  endtask

  task automatic test_abort();
    do_reset();
    do_start();
    bus.req = 2'b01;
    for (int i = 1; i <= 6; i++) tick();
    checks++; if (bus.rnd_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid: got %b expected 1", bus.rnd_valid); end
    bus.req = 2'b00; tick();
    checks++; if (bus.rnd_valid !== 1'b0 || bus.gnt !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL abort_drop: got valid=%b gnt=%b busy=%b expected 0 00 0", bus.rnd_valid, bus.gnt, busy); end
    bus.req = 2'b11;
    for (int i = 1; i <= 6; i++) tick();
    checks++; if (bus.gnt !== 2'b01 || bus.rnd_data !== 17'h02800) begin errors++; $display("FAIL abort_next: got gnt=%b data=%h expected 01 02800", bus.gnt, bus.rnd_data); end
    bus.ack = 2'b01; bus.req = 2'b00; tick(); bus.ack = 2'b00;
  endtask

  task automatic test_reset_mid();
    int active;
    do_reset();
    do_start();
    bus.req = 2'b01;
    tick(); tick();
    checks++; if (lfsr_sh_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_shift: got %b expected 1", lfsr_sh_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (lfsr_sh_en !== 1'b0 || busy !== 1'b0 || bus.rnd_valid !== 1'b0 || bus.gnt !== 2'b00) begin errors++; $display("FAIL midrst_async: got sh_en=%b busy=%b valid=%b gnt=%b expected 0 0 0 00", lfsr_sh_en, busy, bus.rnd_valid, bus.gnt); end
    tick();
    rst_n = 1'b1;
    active = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (lfsr_sh_en || busy || lfsr_rst_en) active++;
    end
    checks++; if (active != 0) begin errors++; $display("FAIL midrst_no_restart: got %0d active cycles expected 0", active); end
    bus.req = 2'b00;
  endtask

  task automatic test_lockup();
    int sh_cnt;
    int v_cnt;
    do_reset();
    do_start();
    bus.req = 2'b01;
    for (int i = 1; i <= 5; i++) tick();
    force_zero = 1'b1;
    tick();
    force_zero = 1'b0;
`ifdef LFSR_SCHED_LOCKUP_DETECT_EN
    checks++; if (lock_err !== 1'b1 || lfsr_rst_en !== 1'b1 || bus.rnd_valid !== 1'b0) begin errors++; $display("FAIL lock_detect: got lock_err=%b rst_en=%b valid=%b expected 1 1 0", lock_err, lfsr_rst_en, bus.rnd_valid); end
    sh_cnt = 0; v_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (lfsr_sh_en) sh_cnt++;
      if (i < 6 && bus.rnd_valid) v_cnt++;
    end
    checks++; if (sh_cnt != 4 || v_cnt != 0) begin errors++; $display("FAIL lock_reshift: got sh=%0d early_valid=%0d expected 4 0", sh_cnt, v_cnt); end
    checks++; if (bus.rnd_valid !== 1'b1 || bus.gnt !== 2'b01 || bus.rnd_data !== 17'h00280) begin errors++; $display("FAIL lock_deliver: got valid=%b gnt=%b data=%h expected 1 01 00280", bus.rnd_valid, bus.gnt, bus.rnd_data); end
    bus.ack = 2'b01; bus.req = 2'b00; tick(); bus.ack = 2'b00;
    checks++; if (lock_err !== 1'b1) begin errors++; $display("FAIL lock_sticky: got %b expected 1", lock_err); end
`else
    sh_cnt = 0; v_cnt = 0;
    checks++; if (bus.rnd_valid !== 1'b1 || bus.gnt !== 2'b01 || bus.rnd_data !== 17'h0) begin errors++; $display("FAIL zero_deliver: got valid=%b gnt=%b data=%h expected 1 01 00000", bus.rnd_valid, bus.gnt, bus.rnd_data); end
    checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL zero_lock_err: got %b expected 0", lock_err); end
    bus.ack = 2'b01; bus.req = 2'b00; tick(); bus.ack = 2'b00;
    checks++; if (lock_err !== 1'b0 || bus.rnd_valid !== 1'b0 || sh_cnt != v_cnt) begin errors++; $display("FAIL zero_release: got lock_err=%b valid=%b expected 0 0", lock_err, bus.rnd_valid); end
`endif
  endtask

  task automatic test_period();
    do_reset();
    lfsr_max_tick = 1'b1;
    tick(); tick(); tick();
    checks++; if (period_cnt !== 8'h00) begin errors++; $display("FAIL period_idle: got %h expected 00", period_cnt); end
    lfsr_max_tick = 1'b0;
    do_start();
    lfsr_max_tick = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    checks++; if (period_cnt !== 8'hFF) begin errors++; $display("FAIL period_255: got %h expected ff", period_cnt); end
    tick();
    checks++; if (period_cnt !== 8'h00) begin errors++; $display("FAIL period_wrap: got %h expected 00", period_cnt); end
    for (int i = 0; i < 5; i++) tick();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (period_cnt !== 8'h06) begin errors++; $display("FAIL period_count: got %h expected 06", period_cnt); end
    tick();
    checks++; if (period_cnt !== 8'h00) begin errors++; $display("FAIL period_init_wins: got %h expected 00", period_cnt); end
    lfsr_max_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_delayed_ack();
    test_abort();
    test_reset_mid();
    test_lockup();
    test_period();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
